// File: rtl/mac_pkg.sv
// Shared widths and FSM state encoding for the MAC operand sequencer.
package mac_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Operand stream, command, MAC feed and result bundle of the dot-product sequencer.
interface mac_dot_sequencer_if #(
  parameter int LEN_W = 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [mac_pkg::OP_W-1:0]   in_a;
  logic [mac_pkg::OP_W-1:0]   in_b;
  logic                       start;
  logic [LEN_W-1:0]           len;
  logic                       busy;
  logic                       op_valid;
  logic [mac_pkg::OP_W-1:0]   op_a;
  logic [mac_pkg::OP_W-1:0]   op_b;
  logic                       acc_clr;
  logic [mac_pkg::ACC_W-1:0]  mac_acc;
  logic                       res_valid;
  logic                       res_ready;
  logic [mac_pkg::ACC_W-1:0]  res_data;

  // Environment side: operand producer, MAC datapath and result consumer.
  modport master (
    output in_valid, in_a, in_b, start, len, mac_acc, res_ready,
    input  in_ready, busy, op_valid, op_a, op_b, acc_clr, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, start, len, mac_acc, res_ready,
    output in_ready, busy, op_valid, op_a, op_b, acc_clr, res_valid, res_data
  );

endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous operand-pair FIFO; read data is the current head (no fall-through of a same-cycle push).
module mac_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds LEN buffered operand pairs to the MAC, waits out its latency and holds the dot product.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input logic                clk,
  input logic                rst_n,
  mac_dot_sequencer_if.slave bus
);

  localparam int DC_W = $clog2(MAC_LAT + 2);

  state_t              state;
  state_t              state_next;
  logic [LEN_W-1:0]    rem;
  logic [DC_W-1:0]     dcnt;

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [2*OP_W-1:0]   head;

  logic                launch;
  logic                zero_run;
  logic                last_pop;
  logic                capture;
  logic                op_valid_next;
  logic [OP_W-1:0]     op_a_next;
  logic [OP_W-1:0]     op_b_next;

  logic                op_valid_reg;
  logic [OP_W-1:0]     op_a_reg;
  logic [OP_W-1:0]     op_b_reg;
  logic                acc_clr_reg;
  logic [ACC_W-1:0]    res_data_reg;

  assign push = bus.in_valid && !full;

  mac_op_fifo #(
    .DEPTH (DEPTH),
    .W     (2*OP_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (zero_run)      state_next = ST_DONE;
                else if (launch)   state_next = ST_CLEAR;
      ST_CLEAR: if (last_pop)      state_next = ST_DRAIN;
                else               state_next = ST_RUN;
      ST_RUN:   if (last_pop)      state_next = ST_DRAIN;
      ST_DRAIN: if (capture)       state_next = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_next = ST_IDLE;
      default:                     state_next = ST_IDLE;
    endcase
  end

  // The clear cycle is also the first issue slot, so a queued pair reaches
  // the MAC on the cycle right after acc_clr.
  always_comb begin
    launch        = (state == ST_IDLE) && bus.start && (bus.len != '0);
    zero_run      = (state == ST_IDLE) && bus.start && (bus.len == '0);
    pop           = ((state == ST_CLEAR) || (state == ST_RUN)) && !empty;
    last_pop      = pop && (rem == LEN_W'(1));
    capture       = (state == ST_DRAIN) && (dcnt == DC_W'(1));
    op_valid_next = pop;
    op_a_next     = pop ? head[2*OP_W-1:OP_W] : '0;
    op_b_next     = pop ? head[OP_W-1:0]      : '0;
  end

  // dcnt spans the cycle of the last op plus MAC_LAT, so the capture sees
  // mac_acc once it includes the final product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem          <= '0;
      dcnt         <= '0;
      op_valid_reg <= 1'b0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      acc_clr_reg  <= 1'b0;
      res_data_reg <= '0;
    end else begin
      op_valid_reg <= op_valid_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      acc_clr_reg  <= launch;
      if (launch)   rem <= bus.len;
      else if (pop) rem <= rem - LEN_W'(1);
      if (last_pop)                dcnt <= DC_W'(MAC_LAT + 1);
      else if (state == ST_DRAIN)  dcnt <= dcnt - DC_W'(1);
      if (zero_run)     res_data_reg <= '0;
      else if (capture) res_data_reg <= bus.mac_acc;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.res_valid = (state == ST_DONE);
  assign bus.op_valid  = op_valid_reg;
  assign bus.op_a      = op_a_reg;
  assign bus.op_b      = op_b_reg;
  assign bus.acc_clr   = acc_clr_reg;
  assign bus.res_data  = res_data_reg;

endmodule
